// File: rtl/imem.sv
// Instruction memory: word-addressed, combinational read, byte-enabled
// program-load write port, contents cleared to NOP by async reset.
module imem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   a,
  output logic [DATA_W-1:0]   rd,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: reset wipes every word at once; writes merge enabled bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[wa][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  // Read is a pure mux on the stored array; no bypass of write data.
  always_comb begin
    rd = mem[a];
  end

endmodule

// File: tb/tb_imem.sv
// Directed self-checking bench for imem.
// Linear sequence of stimulus steps with immediate assertions.
module tb_imem;

  logic        clk;
  logic        rst_n;
  logic [5:0]  a;
  logic [31:0] rd;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [3:0]  wbe;

  int tests = 0;
  int fails = 0;

  imem #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .rd    (rd),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .wbe   (wbe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] addr,
                    input logic [31:0] data,
                    input logic [3:0] be);
    @(negedge clk);
    we  = 1'b1;
    wa  = addr;
    wd  = data;
    wbe = be;
    @(posedge clk);
    #1;
    we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    a     = '0;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    wbe   = '0;
    #1;
    rst_n = 1'b0;
    #1;
    a = 6'h3F;
    #1;
    check("rst_rd_3f", rd, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // sweep after reset
    a = 6'h00; #10; check("sweep_00", rd, 32'h0);
    a = 6'h20; #10; check("sweep_20", rd, 32'h0);
    a = 6'h3F; #10; check("sweep_3f", rd, 32'h0);

    // program load and combinational read
    wr(6'h00, 32'h20080005, 4'hF);
    wr(6'h20, 32'hAC080004, 4'hF);
    wr(6'h3F, 32'h08000000, 4'hF);
    a = 6'h00; #1; check("load_00", rd, 32'h20080005);
    a = 6'h20; #1; check("load_20", rd, 32'hAC080004);
    a = 6'h3F; #1; check("load_3f", rd, 32'h08000000);

    // byte enables
    wr(6'h10, 32'h11223344, 4'hF);
    wr(6'h10, 32'hAABBCCDD, 4'b0101);
    a = 6'h10; #1; check("wbe_0101", rd, 32'h11BB33DD);
    wr(6'h10, 32'hFFFFFFFF, 4'b0000);
    #1; check("wbe_0000", rd, 32'h11BB33DD);
    wr(6'h10, 32'h99887766, 4'b1010);
    #1; check("wbe_1010", rd, 32'h99BB77DD);

    // read during write, same address
    wr(6'h05, 32'h12345678, 4'hF);
    wr(6'h06, 32'h0BADF00D, 4'hF);
    a = 6'h05;
    @(negedge clk);
    we  = 1'b1;
    wa  = 6'h05;
    wd  = 32'hCAFEBABE;
    wbe = 4'hF;
    #1; check("rdw_before", rd, 32'h12345678);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_after", rd, 32'hCAFEBABE);
    a = 6'h06; #1; check("rdw_neighbor", rd, 32'h0BADF00D);

    // writes elsewhere do not disturb rd
    a = 6'h00;
    wr(6'h01, 32'hDEADBEEF, 4'hF);
    check("other_addr", rd, 32'h20080005);

    // mid-program reset
    wr(6'h3F, 32'hFFFFFFFF, 4'hF);
    a = 6'h3F; #1; check("pre_rst_3f", rd, 32'hFFFFFFFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1; check("rst_now_3f", rd, 32'h0);
    we  = 1'b1;
    wa  = 6'h3F;
    wd  = 32'hFFFFFFFF;
    wbe = 4'hF;
    @(posedge clk);
    #1; check("rst_wr_ign", rd, 32'h0);
    a = 6'h00; #1; check("rst_clr_00", rd, 32'h0);
    a = 6'h05; #1; check("rst_clr_05", rd, 32'h0);

    // first-cycle write after deassertion
    @(negedge clk);
    wa    = 6'h01;
    wd    = 32'h55AA55AA;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    a = 6'h01; #1; check("post_rst_wr", rd, 32'h55AA55AA);
    a = 6'h3F; #1; check("post_rst_3f", rd, 32'h0);

    // aliasing sweep
    for (int i = 0; i < 64; i++) begin
      wr(6'(i), {26'b0, 6'(i)}, 4'hF);
    end
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      #1;
      check($sformatf("alias_%02h", i), rd, {26'b0, 6'(i)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
